// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one line-wide memory port shared by the I-cache (fills) and
// the D-cache (fills and write-backs). D has priority, but I is forced through
// after STARVE_LIMIT consecutive D grants that it had to sit out.
// Optional grant/wait statistics are compiled in when ARB_STATS_EN is defined.
//
// Handshake: every requester holds its request level-high until it sees its own
// one-cycle completion pulse. The memory sees one registered command per grant,
// and that command completes on inputReady (read) or ackOutput (write).
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int LINE_WORDS   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_read_m,
    input  logic [WORD_SIZE-1:0]            i_address,
    output logic [WORD_SIZE*LINE_WORDS-1:0] i_data,
    output logic                            i_inputReady,
    input  logic                            d_read_m,
    input  logic                            d_write_m,
    input  logic [WORD_SIZE-1:0]            d_address,
    input  logic [WORD_SIZE*LINE_WORDS-1:0] d_wdata,
    output logic [WORD_SIZE*LINE_WORDS-1:0] d_data,
    output logic                            d_inputReady,
    output logic                            d_ackOutput,
    output logic                            read_m,
    output logic                            write_m,
    output logic [WORD_SIZE-1:0]            address,
    output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
    input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
    input  logic                            inputReady,
    input  logic                            ackOutput,
    output logic                            busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]                     stat_i_grants,
    output logic [15:0]                     stat_d_grants,
    output logic [15:0]                     stat_wait_cycles
`endif
);

    localparam int          LW         = WORD_SIZE * LINE_WORDS;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, SERV_I, SERV_D} state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] address_q, address_d;
    logic [LW-1:0]        mem_wdata_q, mem_wdata_d;
    logic                 op_write_q, op_write_d;
    logic [3:0]           starve_cnt_q, starve_cnt_d;

    logic d_req;
    logic i_wins;

    // I wins when D is silent, or when I has already sat out STARVE_LIMIT D grants.
    assign d_req  = d_read_m | d_write_m;
    assign i_wins = i_read_m & (~d_req | (starve_cnt_q == STARVE_LIM));

    // Data buses are plain pass-throughs; only the ready pulses qualify them.
    assign i_data    = mem_rdata;
    assign d_data    = mem_rdata;
    assign address   = address_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

    // Arbitration, command latching and completion routing.
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        mem_wdata_d  = mem_wdata_q;
        op_write_d   = op_write_q;
        starve_cnt_d = starve_cnt_q;
        read_m       = 1'b0;
        write_m      = 1'b0;
        i_inputReady = 1'b0;
        d_inputReady = 1'b0;
        d_ackOutput  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_read_m) begin
                    starve_cnt_d = '0;
                end
                if (i_wins) begin
                    state_d      = SERV_I;
                    address_d    = i_address;
                    op_write_d   = 1'b0;
                    starve_cnt_d = '0;
                end else if (d_req) begin
                    // A simultaneous read+write from D is served as the write.
                    state_d     = SERV_D;
                    address_d   = d_address;
                    op_write_d  = d_write_m;
                    mem_wdata_d = d_wdata;
                    if (i_read_m && (starve_cnt_q != STARVE_LIM)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end
            end
            SERV_I: begin
                read_m = 1'b1;
                if (inputReady) begin
                    i_inputReady = 1'b1;
                    state_d      = IDLE;
                end
            end
            SERV_D: begin
                read_m  = ~op_write_q;
                write_m = op_write_q;
                if (op_write_q && ackOutput) begin
                    d_ackOutput = 1'b1;
                    state_d     = IDLE;
                end else if (!op_write_q && inputReady) begin
                    d_inputReady = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched command registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            address_q    <= '0;
            mem_wdata_q  <= '0;
            op_write_q   <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            mem_wdata_q  <= mem_wdata_d;
            op_write_q   <= op_write_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stat_i_q, stat_i_d;
    logic [15:0] stat_d_q, stat_d_d;
    logic [15:0] stat_w_q, stat_w_d;
    logic        grant_i, grant_d, i_wait, d_wait;

    // A requester waits in any cycle it is pending but neither granted nor in service.
    always_comb begin
        grant_i  = (state_q == IDLE) & i_wins;
        grant_d  = (state_q == IDLE) & ~i_wins & d_req;
        i_wait   = i_read_m & (state_q != SERV_I) & ~grant_i;
        d_wait   = d_req & (state_q != SERV_D) & ~grant_d;
        stat_i_d = stat_i_q + 16'(grant_i);
        stat_d_d = stat_d_q + 16'(grant_d);
        stat_w_d = stat_w_q + 16'(i_wait | d_wait);
    end

    // Statistics counters, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_i_q <= '0;
            stat_d_q <= '0;
            stat_w_q <= '0;
        end else begin
            stat_i_q <= stat_i_d;
            stat_d_q <= stat_d_d;
            stat_w_q <= stat_w_d;
        end
    end

    assign stat_i_grants    = stat_i_q;
    assign stat_d_grants    = stat_d_q;
    assign stat_wait_cycles = stat_w_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized phase, all
// checked against a small model of the arbitration rules (who should win, what
// command the memory should see, which side gets the completion pulse).
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read_m;
    logic [15:0] i_address;
    logic [63:0] i_data;
    logic        i_inputReady;
    logic        d_read_m;
    logic        d_write_m;
    logic [15:0] d_address;
    logic [63:0] d_wdata;
    logic [63:0] d_data;
    logic        d_inputReady;
    logic        d_ackOutput;
    logic        read_m;
    logic        write_m;
    logic [15:0] address;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        inputReady;
    logic        ackOutput;
    logic        busy;
`ifdef ARB_STATS_EN
    logic [15:0] stat_i_grants;
    logic [15:0] stat_d_grants;
    logic [15:0] stat_wait_cycles;
`endif

    // Clock
    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD_SIZE(16), .LINE_WORDS(4), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .i_read_m(i_read_m), .i_address(i_address), .i_data(i_data), .i_inputReady(i_inputReady),
        .d_read_m(d_read_m), .d_write_m(d_write_m), .d_address(d_address), .d_wdata(d_wdata),
        .d_data(d_data), .d_inputReady(d_inputReady), .d_ackOutput(d_ackOutput),
        .read_m(read_m), .write_m(write_m), .address(address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .inputReady(inputReady), .ackOutput(ackOutput), .busy(busy)
`ifdef ARB_STATS_EN
        , .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
        .stat_wait_cycles(stat_wait_cycles)
`endif
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Model: how many D grants in a row I has had to sit through.
    int          d_streak = 0;
    logic [15:0] exp_q[$];
    bit          last_obs_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full grant: called at a negedge with requests already applied and the
    // arbiter idle. Returns at the following bubble cycle with the winner dropped.
    task automatic run_access(input int lat, input bit noise);
        bit          i_req, d_req, win_i, wr;
        logic [15:0] ea;
        logic [63:0] ewd, rd;
        i_req = i_read_m;
        d_req = d_read_m | d_write_m;
        win_i = i_req && (!d_req || d_streak >= STARVE_LIMIT);
        wr    = !win_i && d_write_m;
        ea    = win_i ? i_address : d_address;
        ewd   = d_wdata;
        if (win_i) d_streak = 0;
        else if (i_req) d_streak = (d_streak < STARVE_LIMIT) ? d_streak + 1 : d_streak;
        else d_streak = 0;
        exp_q.push_back(ea);

        #1;
        chk("strobe_before_grant", {read_m, write_m}, 2'b00);
        @(negedge clk);
        inputReady = 1'b0;
        ackOutput  = 1'b0;
        #1;
        chk("read_m_granted", read_m, !wr);
        chk("write_m_granted", write_m, wr);
        chk("address_granted", address, exp_q.pop_front());
        chk("busy_granted", busy, 1'b1);
        if (wr) chk("mem_wdata", mem_wdata, ewd);

        for (int c = 0; c < lat; c++) begin
            if (noise && $urandom_range(0, 3) == 0) begin
                if (win_i) i_read_m = 1'b0;
                else begin d_read_m = 1'b0; d_write_m = 1'b0; end
            end
            if (noise) begin
                if (wr) inputReady = 1'($urandom_range(0, 1));
                else    ackOutput  = 1'($urandom_range(0, 1));
            end
            #1;
            chk("no_pulse_waiting", {i_inputReady, d_inputReady, d_ackOutput}, 3'b000);
            @(negedge clk);
            inputReady = 1'b0;
            ackOutput  = 1'b0;
            #1;
            chk("strobe_held", {read_m, write_m}, {!wr, wr});
        end

        rd        = {$urandom, $urandom};
        mem_rdata = rd;
        if (wr) ackOutput = 1'b1;
        else    inputReady = 1'b1;
        #1;
        last_obs_i = i_inputReady;
        chk("i_inputReady_done", i_inputReady, win_i);
        chk("d_inputReady_done", d_inputReady, !win_i && !wr);
        chk("d_ackOutput_done", d_ackOutput, wr);
        if (!wr) chk("rdata_routed", win_i ? i_data : d_data, rd);

        @(negedge clk);
        inputReady = 1'b0;
        ackOutput  = 1'b0;
        if (win_i) i_read_m = 1'b0;
        else begin d_read_m = 1'b0; d_write_m = 1'b0; end
        if (noise) begin
            inputReady = 1'($urandom_range(0, 1));
            ackOutput  = 1'($urandom_range(0, 1));
        end
        #1;
        chk("bubble_idle", {busy, read_m, write_m}, 3'b000);
        chk("bubble_no_pulse", {i_inputReady, d_inputReady, d_ackOutput}, 3'b000);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_read_m = 1'b0; d_read_m = 1'b0; d_write_m = 1'b0;
        inputReady = 1'b0; ackOutput = 1'b0;
        d_streak = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] order;
        reset = 1'b1;
        i_read_m = 1'b0; i_address = '0;
        d_read_m = 1'b0; d_write_m = 1'b0; d_address = '0; d_wdata = '0;
        mem_rdata = '0; inputReady = 1'b0; ackOutput = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_strobes", {read_m, write_m, busy}, 3'b000);
        chk("reset_pulses", {i_inputReady, d_inputReady, d_ackOutput}, 3'b000);
        chk("reset_address", address, 16'h0000);
        chk("reset_mem_wdata", mem_wdata, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Lone I fill.
        i_read_m = 1'b1; i_address = 16'h0040;
        run_access(3, 1'b0);

        // I and D read together: D first, bubble, then I.
        i_read_m = 1'b1; i_address = 16'h0080;
        d_read_m = 1'b1; d_address = 16'h0200;
        run_access(1, 1'b0);
        chk("t2_first_is_d", last_obs_i, 1'b0);
        run_access(2, 1'b0);
        chk("t2_second_is_i", last_obs_i, 1'b1);

        // D write-back.
        d_write_m = 1'b1; d_address = 16'h0100; d_wdata = 64'h1111_2222_3333_4444;
        run_access(2, 1'b0);

        // D continuously requesting while I waits: D,D,D,I,D,D,D,I.
        order = '0;
        i_read_m = 1'b1; i_address = 16'h0480;
        for (int g = 0; g < 8; g++) begin
            d_read_m = 1'b1; d_address = 16'h1000 + 16'(g * 4);
            if (!i_read_m) begin i_read_m = 1'b1; i_address = 16'h0480 + 16'(g * 4); end
            run_access(1, 1'b0);
            order = {order[6:0], last_obs_i};
        end
        chk("t4_grant_order", order, 8'b0001_0001);
        d_read_m = 1'b0;
        @(negedge clk);
        d_streak = 0;

        // Reset during a D read.
        d_read_m = 1'b1; d_address = 16'h0300;
        @(negedge clk);
        #1;
        chk("t5_read_m_serving", read_m, 1'b1);
        reset = 1'b1;
        d_read_m = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_read_m_after_reset", read_m, 1'b0);
        chk("t5_busy_after_reset", busy, 1'b0);
        chk("t5_address_after_reset", address, 16'h0000);
        reset = 1'b0;
        d_streak = 0;
        @(negedge clk);
        inputReady = 1'b1;
        ackOutput  = 1'b1;
        #1;
        chk("t5_late_ready_dropped", {i_inputReady, d_inputReady, d_ackOutput}, 3'b000);
        @(negedge clk);
        inputReady = 1'b0;
        ackOutput  = 1'b0;

        // Randomized traffic, with mid-service drops and stray responses.
        for (int k = 0; k < 40; k++) begin
            int op;
            if (!i_read_m && $urandom_range(0, 1) == 1) begin
                i_read_m  = 1'b1;
                i_address = 16'($urandom) & 16'hFFFC;
            end
            if (!(d_read_m || d_write_m) && $urandom_range(0, 2) != 0) begin
                op        = int'($urandom_range(0, 4));
                d_read_m  = (op <= 2) || (op == 4);
                d_write_m = (op >= 3);
                d_address = 16'($urandom) & 16'hFFFC;
                d_wdata   = {$urandom, $urandom};
            end
            if (!i_read_m && !d_read_m && !d_write_m) begin
                d_read_m  = 1'b1;
                d_address = 16'($urandom) & 16'hFFFC;
            end
            run_access(int'($urandom_range(0, 4)), 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            if (i_read_m || d_read_m || d_write_m) run_access(1, 1'b1);
        end
        inputReady = 1'b0;
        ackOutput  = 1'b0;
        @(negedge clk);

`ifdef ARB_STATS_EN
        // Statistics over the simultaneous I/D scenario; I waits 1 + (lat+1) cycles.
        do_reset();
        i_read_m = 1'b1; i_address = 16'h0080;
        d_read_m = 1'b1; d_address = 16'h0200;
        run_access(2, 1'b0);
        run_access(2, 1'b0);
        chk("stat_d_grants", stat_d_grants, 16'd1);
        chk("stat_i_grants", stat_i_grants, 16'd1);
        chk("stat_wait_cycles", stat_wait_cycles, 16'd4);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
